// File: rtl/bcd_binary_seq.sv
// bcd_binary_seq: sequential BCD-to-binary converter (reverse double-dabble).
// A start strobe latches NDIG packed BCD digits. The converter then shifts one
// bit per clock from the BCD register S into the binary work register B.
// After BIN_W shifts, B holds the value mod 2^BIN_W. Any bits left in S mean
// the value did not fit in BIN_W bits.
//
// Handshake: start is a request that is accepted on any rising edge where the
// block is not busy (state IDLE or DONE). bcd_in is sampled on that same edge
// only. done is a one-cycle response pulse; bin_out and err become valid in
// that cycle and hold until the next done. No ready/backpressure exists on the
// result side: a consumer must capture the result while done is high, or read
// the held value afterwards.
module bcd_binary_seq #(
  parameter int NDIG  = 2,
  parameter int BIN_W = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*NDIG-1:0]   bcd_in,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    bin_out,
  output logic                err,
  output logic [1:0]          state_dbg
);

  localparam int SW = 4 * NDIG;
  localparam int CW = $clog2(BIN_W + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [SW-1:0]    s_reg;
  logic [BIN_W-1:0] b_reg;
  logic [CW-1:0]    cnt;

  logic             digit_bad;
  logic [SW-1:0]    s_next;
  logic [BIN_W-1:0] b_next;
  logic             accept;
  logic             last_shift;

  // Flag the operand as invalid when any of its digits is above 9.
  always_comb begin
    digit_bad = 1'b0;
    for (int d = 0; d < NDIG; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) begin
        digit_bad = 1'b1;
      end
    end
  end

  // One reverse double-dabble step. Shift {S,B} right by one, then correct
  // every digit that is now >= 8. Such a digit absorbed a bit worth 10 from
  // the digit above, which halves to 5, but binary halving gave 8, so the
  // correction subtracts 3.
  always_comb begin
    s_next = {1'b0, s_reg[SW-1:1]};
    b_next = {s_reg[0], b_reg[BIN_W-1:1]};
    for (int d = 0; d < NDIG; d++) begin
      if (s_next[4*d +: 4] >= 4'd8) begin
        s_next[4*d +: 4] = s_next[4*d +: 4] - 4'd3;
      end
    end
  end

  // A new operand can be taken whenever no conversion is running.
  // Accepting it in DONE as well gives back-to-back operation.
  always_comb begin
    accept     = start && ((state == ST_IDLE) || (state == ST_DONE));
    last_shift = (cnt == CW'(BIN_W - 1));
  end

  // Control FSM and datapath registers. bin_out and err are written only on
  // the edges that enter DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      s_reg   <= '0;
      b_reg   <= '0;
      cnt     <= '0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            s_reg <= bcd_in;
            b_reg <= '0;
            cnt   <= '0;
            if (digit_bad) begin
              // Invalid operand: report at once, skip the shifting.
              state   <= ST_DONE;
              bin_out <= '0;
              err     <= 1'b1;
            end else begin
              state <= ST_CONV;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CONV: begin
          s_reg <= s_next;
          b_reg <= b_next;
          cnt   <= cnt + CW'(1);
          if (last_shift) begin
            // Anything left in S is the part of the value at or above 2^BIN_W.
            state   <= ST_DONE;
            bin_out <= b_next;
            err     <= |s_next;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs decode the state register directly. No input reaches them
  // without passing through a flop.
  always_comb begin
    busy      = (state == ST_CONV);
    done      = (state == ST_DONE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_bcd_binary_seq.sv
// Bench for bcd_binary_seq. It drives a 2-digit/7-bit instance and a
// 3-digit/7-bit instance from one clock. A table of directed vectors covers
// plain conversions, and hand-written sequences cover the multi-cycle cases.
module tb_bcd_binary_seq;

  logic        clk;
  logic        rst;

  logic        start0, start1;
  logic [7:0]  bcd0;
  logic [11:0] bcd1;
  logic        busy0, done0, err0, busy1, done1, err1;
  logic [6:0]  bin0, bin1;
  logic [1:0]  st0, st1;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    bit          sel;      // 0: 2-digit instance, 1: 3-digit instance
    logic [11:0] bcd;
    logic [6:0]  exp_bin;
    logic        exp_err;
    int          exp_lat;  // edges after acceptance until done is seen
    int          exp_busy; // cycles with busy high
  } vec_t;

  vec_t vecs[$];

  bcd_binary_seq #(.NDIG(2), .BIN_W(7)) dut2 (
    .clk(clk), .rst(rst), .start(start0), .bcd_in(bcd0),
    .busy(busy0), .done(done0), .bin_out(bin0), .err(err0), .state_dbg(st0)
  );

  bcd_binary_seq #(.NDIG(3), .BIN_W(7)) dut3 (
    .clk(clk), .rst(rst), .start(start1), .bcd_in(bcd1),
    .busy(busy1), .done(done1), .bin_out(bin1), .err(err1), .state_dbg(st1)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Driver: present one operand with a start strobe. Then watch until done,
  // counting busy cycles. lat stays -1 if done never arrives.
  task automatic convert(input bit sel, input logic [11:0] bcd,
                         output logic [6:0] bin, output logic e,
                         output int lat, output int busy_n);
    @(negedge clk);
    if (sel) begin start1 = 1'b1; bcd1 = bcd; end
    else     begin start0 = 1'b1; bcd0 = bcd[7:0]; end
    lat = -1;
    busy_n = 0;
    bin = '0;
    e = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin start0 = 1'b0; start1 = 1'b0; end
      if (sel ? busy1 : busy0) busy_n++;
      if (sel ? done1 : done0) begin
        lat = k;
        bin = sel ? bin1 : bin0;
        e   = sel ? err1 : err0;
        break;
      end
    end
  endtask

  logic [6:0] r_bin;
  logic       r_err;
  int         r_lat, r_busy;
  int         seen;

  initial begin
    // Vector table: {sel, bcd, bin, err, latency, busy cycles}.
    vecs.push_back('{0, 12'h099, 7'd99,  1'b0, 7, 7});
    vecs.push_back('{0, 12'h000, 7'd0,   1'b0, 7, 7});
    vecs.push_back('{0, 12'h042, 7'd42,  1'b0, 7, 7});
    vecs.push_back('{0, 12'h0A5, 7'd0,   1'b1, 0, 0});
    vecs.push_back('{0, 12'h075, 7'd75,  1'b0, 7, 7});
    vecs.push_back('{0, 12'h01C, 7'd0,   1'b1, 0, 0});
    vecs.push_back('{0, 12'h010, 7'd10,  1'b0, 7, 7});
    vecs.push_back('{1, 12'h150, 7'd22,  1'b1, 7, 7});
    vecs.push_back('{1, 12'h127, 7'd127, 1'b0, 7, 7});
    vecs.push_back('{1, 12'h128, 7'd0,   1'b1, 7, 7});
    vecs.push_back('{1, 12'h999, 7'd103, 1'b1, 7, 7});
    vecs.push_back('{1, 12'h0F0, 7'd0,   1'b1, 0, 0});
    vecs.push_back('{1, 12'h064, 7'd64,  1'b0, 7, 7});

    start0 = 1'b0; start1 = 1'b0; bcd0 = '0; bcd1 = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy0", busy0, 0);
    check("reset_done0", done0, 0);
    check("reset_bin0",  bin0,  0);
    check("reset_err0",  err0,  0);
    check("reset_state0", st0,  0);
    check("reset_bin1",  bin1,  0);
    check("reset_err1",  err1,  0);
    rst = 1'b0;

    // Table-driven conversions.
    foreach (vecs[i]) begin
      convert(vecs[i].sel, vecs[i].bcd, r_bin, r_err, r_lat, r_busy);
      check($sformatf("v%0d_lat", i),  r_lat,  vecs[i].exp_lat);
      check($sformatf("v%0d_busy", i), r_busy, vecs[i].exp_busy);
      check($sformatf("v%0d_bin", i),  r_bin,  vecs[i].exp_bin);
      check($sformatf("v%0d_err", i),  r_err,  vecs[i].exp_err);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), vecs[i].sel ? done1 : done0, 0);
      check($sformatf("v%0d_bin_held", i), vecs[i].sel ? bin1 : bin0, vecs[i].exp_bin);
    end

    // start held through CONV with a different operand is ignored.
    @(negedge clk);
    start0 = 1'b1; bcd0 = 8'h42;
    seen = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) bcd0 = 8'h17;
      if (k == 6) start0 = 1'b0;
      if (done0) begin seen = k; break; end
    end
    check("hold_lat", seen, 7);
    check("hold_bin", bin0, 42);
    check("hold_err", err0, 0);
    @(negedge clk);

    // Back-to-back: start in the DONE cycle begins a new conversion with no gap.
    convert(0, 12'h099, r_bin, r_err, r_lat, r_busy);
    check("b2b_first_bin", r_bin, 99);
    check("b2b_first_lat", r_lat, 7);
    start0 = 1'b1; bcd0 = 8'h33;
    @(negedge clk);
    start0 = 1'b0;
    check("b2b_busy_now", busy0, 1);
    check("b2b_done_now", done0, 0);
    seen = -1;
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      if (done0) begin seen = k; break; end
    end
    check("b2b_second_lat", seen, 7);
    check("b2b_second_bin", bin0, 33);
    check("b2b_second_err", err0, 0);
    repeat (2) @(negedge clk);

    // Reset in the third CONV cycle aborts the conversion and clears the outputs.
    convert(0, 12'h042, r_bin, r_err, r_lat, r_busy);
    check("pre_rst_bin", r_bin, 42);
    @(negedge clk);
    start0 = 1'b1; bcd0 = 8'h99;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", busy0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_bin",  bin0,  0);
    check("rst_err",  err0,  0);
    check("rst_state", st0,  0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done0 || busy0) seen++;
    end
    check("rst_no_done", seen, 0);
    convert(0, 12'h057, r_bin, r_err, r_lat, r_busy);
    check("post_rst_lat", r_lat, 7);
    check("post_rst_bin", r_bin, 57);
    check("post_rst_err", r_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
